// File: rtl/bus_mux_arbiter.sv
// Registered bus-mux select arbiter: turns the control unit's out-enable
// vector into a binary select plus a one-hot grant. It supports strict
// one-hot, fixed-priority and round-robin modes, grant hold and
// multi-driver error flags.
module bus_mux_arbiter #(
    parameter int N_SRC       = 26,
    parameter int SEL_W       = 6,
    parameter int DEFAULT_SEL = 31,
    parameter int MODE        = 0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [N_SRC-1:0] req,
    input  logic             hold,
    input  logic             err_clr,
    output logic [SEL_W-1:0] select,
    output logic [N_SRC-1:0] grant,
    output logic             valid,
    output logic             multi_err,
    output logic             err_sticky
);

    localparam logic [SEL_W-1:0] IDLE_SEL = SEL_W'(DEFAULT_SEL);

    // Reject parameter sets that cannot encode every source or the idle code.
    if (N_SRC < 1 || SEL_W < 1 || SEL_W > 30 || (1 << SEL_W) <= N_SRC ||
        DEFAULT_SEL < N_SRC || DEFAULT_SEL >= (1 << SEL_W) ||
        MODE < 0 || MODE > 2) begin : g_param_err
        $error("bus_mux_arbiter: illegal parameter combination");
    end

    logic [SEL_W-1:0] select_q, select_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             multi_q, multi_d;
    logic             sticky_q, sticky_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             lo_found;
    logic [SEL_W-1:0] lo_idx;
    logic             rr_found;
    logic [SEL_W-1:0] rr_idx;
    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic             hold_keep;
    int               n_set;

    // Count active requesters; more than one means a bus fight.
    always_comb begin
        n_set = 0;
        for (int i = 0; i < N_SRC; i++) begin
            if (req[i]) n_set = n_set + 1;
        end
    end

    // Fixed priority: the lowest set index wins.
    always_comb begin
        lo_found = |req;
        lo_idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) lo_idx = SEL_W'(i);
        end
    end

    // Round robin: rotate req so that the pointer sits at bit 0, take the
    // lowest set bit, then map that offset back to an absolute index.
    always_comb begin
        logic [2*N_SRC-1:0] dbl;
        logic [N_SRC-1:0]   rot;
        int                 off;
        int                 abs_idx;
        dbl      = {req, req} >> ptr_q;
        rot      = dbl[N_SRC-1:0];
        off      = 0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        abs_idx  = int'(ptr_q) + off;
        if (abs_idx >= N_SRC) abs_idx = abs_idx - N_SRC;
        rr_found = |req;
        rr_idx   = SEL_W'(abs_idx);
    end

    // Pick the winner for the configured mode. Strict mode only accepts
    // exactly one requester.
    always_comb begin
        if (MODE == 0) begin
            win_found = (n_set == 1);
            win_idx   = lo_idx;
        end else if (MODE == 1) begin
            win_found = lo_found;
            win_idx   = lo_idx;
        end else begin
            win_found = rr_found;
            win_idx   = rr_idx;
        end
    end

    // Hold keeps the current owner only while it is still requesting.
    // grant_q is one-hot, so masking req with it gives req[current].
    assign hold_keep = (MODE != 0) && hold && valid_q && (|(req & grant_q));

    // Next-state computation for the grant, the pointer and the error flags.
    always_comb begin
        select_d = IDLE_SEL;
        grant_d  = '0;
        valid_d  = 1'b0;
        ptr_d    = ptr_q;
        if (hold_keep) begin
            select_d = select_q;
            grant_d  = grant_q;
            valid_d  = 1'b1;
        end else if (win_found) begin
            select_d = win_idx;
            valid_d  = 1'b1;
            for (int i = 0; i < N_SRC; i++) begin
                grant_d[i] = (win_idx == SEL_W'(i));
            end
            if (MODE == 2) begin
                ptr_d = (int'(win_idx) == N_SRC - 1) ? '0 : win_idx + 1'b1;
            end
        end
        multi_d  = (n_set > 1);
        // A new error outranks a clear in the same cycle.
        sticky_d = multi_d | (sticky_q & ~err_clr);
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            select_q <= IDLE_SEL;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            multi_q  <= 1'b0;
            sticky_q <= 1'b0;
            ptr_q    <= '0;
        end else begin
            select_q <= select_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            multi_q  <= multi_d;
            sticky_q <= sticky_d;
            ptr_q    <= ptr_d;
        end
    end

    assign select     = select_q;
    assign grant      = grant_q;
    assign valid      = valid_q;
    assign multi_err  = multi_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Scoreboard bench for bus_mux_arbiter. One instance per mode is driven by
// shared stimulus. A queue-based reference model predicts each edge, and a
// monitor pops and compares the predictions.
module tb_bus_mux_arbiter;

    localparam int N  = 26;
    localparam int SW = 6;
    localparam int DS = 31;

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic [N-1:0]  req = '0;
    logic          hold = 1'b0;
    logic          err_clr = 1'b0;

    logic [SW-1:0] sel_a [3];
    logic [N-1:0]  gnt_a [3];
    logic          vld_a [3];
    logic          mer_a [3];
    logic          stk_a [3];

    always #5 clock = ~clock;

    bus_mux_arbiter #(.N_SRC(N), .SEL_W(SW), .DEFAULT_SEL(DS), .MODE(0)) u_m0 (
        .clock(clock), .clear(clear), .req(req), .hold(hold), .err_clr(err_clr),
        .select(sel_a[0]), .grant(gnt_a[0]), .valid(vld_a[0]),
        .multi_err(mer_a[0]), .err_sticky(stk_a[0]));
    bus_mux_arbiter #(.N_SRC(N), .SEL_W(SW), .DEFAULT_SEL(DS), .MODE(1)) u_m1 (
        .clock(clock), .clear(clear), .req(req), .hold(hold), .err_clr(err_clr),
        .select(sel_a[1]), .grant(gnt_a[1]), .valid(vld_a[1]),
        .multi_err(mer_a[1]), .err_sticky(stk_a[1]));
    bus_mux_arbiter #(.N_SRC(N), .SEL_W(SW), .DEFAULT_SEL(DS), .MODE(2)) u_m2 (
        .clock(clock), .clear(clear), .req(req), .hold(hold), .err_clr(err_clr),
        .select(sel_a[2]), .grant(gnt_a[2]), .valid(vld_a[2]),
        .multi_err(mer_a[2]), .err_sticky(stk_a[2]));

    typedef struct packed {
        logic [2:0][SW-1:0] sel;
        logic [2:0][N-1:0]  gnt;
        logic [2:0]         vld;
        logic [2:0]         mer;
        logic [2:0]         stk;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state, one entry per mode.
    int m_sel [3];
    bit m_vld [3];
    int m_ptr [3];
    bit m_stk [3];

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic bit bitof(input logic [N-1:0] r, input int i);
        return ((r >> i) & 1) != 0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            m_sel[m] = DS; m_vld[m] = 0; m_ptr[m] = 0; m_stk[m] = 0;
        end
    endtask

    // Apply one sampled input set to all three models and report the
    // outputs expected after that edge.
    task automatic model_step(input logic [N-1:0] r, input bit h, input bit ec,
                              output exp_t e);
        int  setq[$];
        int  w, best, d;
        bit  held, multi;
        setq = {};
        for (int i = 0; i < N; i++) if (bitof(r, i)) setq.push_back(i);
        multi = setq.size() > 1;
        e = '0;
        for (int m = 0; m < 3; m++) begin
            held = (m != 0) && h && m_vld[m] && bitof(r, m_sel[m]);
            if (!held) begin
                w = -1;
                if (setq.size() != 0) begin
                    if (m == 0) w = (setq.size() == 1) ? setq[0] : -1;
                    else if (m == 1) w = setq[0];
                    else begin
                        best = N;
                        foreach (setq[k]) begin
                            d = (setq[k] - m_ptr[m] + N) % N;
                            if (d < best) begin best = d; w = setq[k]; end
                        end
                    end
                end
                if (w < 0) begin
                    m_vld[m] = 0; m_sel[m] = DS;
                end else begin
                    m_vld[m] = 1; m_sel[m] = w;
                    if (m == 2) m_ptr[m] = (w + 1) % N;
                end
            end
            m_stk[m]   = multi || (m_stk[m] && !ec);
            e.sel[m]   = SW'(m_sel[m]);
            e.gnt[m]   = m_vld[m] ? (N'(1) << m_sel[m]) : '0;
            e.vld[m]   = m_vld[m];
            e.mer[m]   = multi;
            e.stk[m]   = m_stk[m];
        end
    endtask

    // Drive one cycle at the falling edge and queue its prediction.
    task automatic cycle(input logic [N-1:0] r, input bit h, input bit ec);
        exp_t e;
        @(negedge clock);
        clear = 1'b1; req = r; hold = h; err_clr = ec;
        model_step(r, h, ec, e);
        expq.push_back(e);
    endtask

    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    // Monitor: compare the DUT with the oldest prediction and check the
    // select/grant consistency every cycle while out of reset.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (clear) begin
            if (expq.size() != 0) begin
                e = expq.pop_front();
                for (int m = 0; m < 3; m++) begin
                    chk($sformatf("sb_select_m%0d", m), sel_a[m], e.sel[m]);
                    chk($sformatf("sb_grant_m%0d", m), gnt_a[m], e.gnt[m]);
                    chk($sformatf("sb_valid_m%0d", m), vld_a[m], e.vld[m]);
                    chk($sformatf("sb_multi_m%0d", m), mer_a[m], e.mer[m]);
                    chk($sformatf("sb_sticky_m%0d", m), stk_a[m], e.stk[m]);
                end
            end
            for (int m = 0; m < 3; m++) begin
                if (vld_a[m])
                    chk($sformatf("inv_onehot_m%0d", m), gnt_a[m],
                        (int'(sel_a[m]) < N) ? (N'(1) << sel_a[m]) : '1);
                else
                    chk($sformatf("inv_idle_m%0d", m), {sel_a[m], gnt_a[m]},
                        {SW'(DS), N'(0)});
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] last_r;
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("rst_select_m%0d", m), sel_a[m], DS);
            chk($sformatf("rst_grant_m%0d", m), gnt_a[m], 0);
            chk($sformatf("rst_valid_m%0d", m), vld_a[m], 0);
            chk($sformatf("rst_multi_m%0d", m), mer_a[m], 0);
            chk($sformatf("rst_sticky_m%0d", m), stk_a[m], 0);
        end

        // Strict mode: single request, idle, multi-driver, sticky handling.
        cycle(N'(32'h0000_0400), 0, 0); settle();
        chk("m0_single_sel", sel_a[0], 10);
        chk("m0_single_vld", vld_a[0], 1);
        chk("m0_single_gnt", gnt_a[0], N'(32'h0000_0400));
        cycle('0, 0, 0); settle();
        chk("m0_idle_sel", sel_a[0], DS);
        chk("m0_idle_vld", vld_a[0], 0);
        cycle(N'((1 << 3) | (1 << 7)), 0, 0); settle();
        chk("m0_multi_sel", sel_a[0], DS);
        chk("m0_multi_vld", vld_a[0], 0);
        chk("m0_multi_err", mer_a[0], 1);
        chk("m0_multi_sticky", stk_a[0], 1);
        cycle('0, 0, 0); settle();
        chk("m0_err_pulse_end", mer_a[0], 0);
        chk("m0_sticky_held", stk_a[0], 1);
        cycle(N'((1 << 3) | (1 << 7)), 0, 1); settle();
        chk("m0_sticky_set_wins", stk_a[0], 1);
        cycle('0, 0, 1); settle();
        chk("m0_sticky_cleared", stk_a[0], 0);

        // Fixed priority with hold.
        cycle(N'((1 << 5) | (1 << 2)), 0, 0); settle();
        chk("m1_prio_sel", sel_a[1], 2);
        chk("m1_prio_vld", vld_a[1], 1);
        chk("m1_prio_err", mer_a[1], 1);
        cycle(N'((1 << 5) | (1 << 2) | 1), 1, 0); settle();
        chk("m1_hold_sel", sel_a[1], 2);
        cycle(N'((1 << 5) | 1), 1, 0); settle();
        chk("m1_hold_drop_sel", sel_a[1], 0);

        // Round robin from a freshly cleared pointer.
        @(negedge clock); clear = 1'b0; model_reset();
        r = N'((1 << 1) | (1 << 4) | (1 << 25));
        cycle(r, 0, 0); settle(); chk("m2_rr_0", sel_a[2], 1);
        cycle(r, 0, 0); settle(); chk("m2_rr_1", sel_a[2], 4);
        cycle(r, 0, 0); settle(); chk("m2_rr_2", sel_a[2], 25);
        cycle(r, 0, 0); settle(); chk("m2_rr_wrap", sel_a[2], 1);
        cycle('0, 0, 0);
        cycle('0, 0, 0);
        cycle(r, 0, 0); settle(); chk("m2_ptr_kept_idle", sel_a[2], 4);

        // Asynchronous clear between edges while select=4.
        #1 clear = 1'b0;
        #1;
        chk("async_sel", sel_a[2], DS);
        chk("async_gnt", gnt_a[2], 0);
        chk("async_vld", vld_a[2], 0);
        model_reset();
        cycle(N'((1 << 1) | (1 << 4)), 0, 0); settle();
        chk("m2_after_clear", sel_a[2], 1);

        // Random traffic across all modes.
        last_r = '0;
        for (int c = 0; c < 10000; c++) begin
            case ($urandom_range(0, 4))
                0: r = '0;
                1: r = N'(1) << $urandom_range(0, N - 1);
                2: r = (N'(1) << $urandom_range(0, N - 1)) |
                       (N'(1) << $urandom_range(0, N - 1));
                3: r = N'($urandom);
                default: r = last_r;
            endcase
            last_r = r;
            cycle(r, bit'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 5 && expq.size() != 0; k++) @(negedge clock);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d predictions left, expected 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
